toll_lane_scheduler: RTL and testbench

Lane scheduler for the toll plaza. It accepts one arriving vehicle per cycle over a valid/ready handshake and assigns it to the least-occupied lane of its class. It also runs a service booth per lane that retires queued vehicles after a fixed class-dependent service time. It sits in front of `toll_traffic_management`: the `lane_count` outputs are the per-lane occupancy that block consumes as its lane inputs.

---
 rtl/toll_pkg.sv | 21 ++
 rtl/toll_lane_booth.sv | 78 +++++++
 rtl/toll_lane_scheduler.sv | 100 ++++++++++
 tb/tb_toll_lane_scheduler.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/toll_pkg.sv
// rtl/toll_pkg.sv - shared lane constants and booth state type for the toll lane scheduler
package toll_pkg;

  localparam int CW        = 3;
  localparam int NUM_LANES = 6;

  localparam logic [CW-1:0] CNT_MAX = 3'd7;

  localparam logic [2:0] PRI_LO  = 3'd1;
  localparam logic [2:0] PRI_HI  = 3'd2;
  localparam logic [2:0] CASH_LO = 3'd3;
  localparam logic [2:0] CASH_HI = 3'd4;
  localparam logic [2:0] ELEC_LO = 3'd5;
  localparam logic [2:0] ELEC_HI = 3'd6;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } booth_state_t;

endpackage

// File: rtl/toll_lane_booth.sv
// rtl/toll_lane_booth.sv - one lane's occupancy count, service timer and departure pulse
module toll_lane_booth
  import toll_pkg::*;
#(
  parameter int SVC = 1,
  parameter int TW  = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          dep_valid
);

  // SVC-1 remaining edges after entering SERVE, plus the departure edge itself,
  // gives exactly SVC edges per vehicle.
  localparam logic [TW-1:0] RELOAD = TW'(SVC - 1);

  booth_state_t  state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [CW-1:0] count_n;
  logic          dep_n;
  logic          depart;

  // State register: reset drops any queued vehicles without a departure pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      count     <= '0;
      dep_valid <= 1'b0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      count     <= count_n;
      dep_valid <= dep_n;
    end
  end

  // Next-state logic: everything freezes while enable is low.
  always_comb begin
    state_n = state;
    timer_n = timer;
    count_n = count;
    dep_n   = 1'b0;
    depart  = 1'b0;
    if (enable) begin
      depart  = (state == SERVE) && (timer == '0);
      // Arrival and departure on the same edge cancel in the count.
      count_n = count + CW'(inc) - CW'(depart);
      case (state)
        IDLE: begin
          if (count != '0) begin
            state_n = SERVE;
            timer_n = RELOAD;
          end
        end
        SERVE: begin
          if (timer != '0) begin
            timer_n = timer - TW'(1);
          end else begin
            dep_n = 1'b1;
            if (count_n != '0) begin
              timer_n = RELOAD;
            end else begin
              state_n = IDLE;
            end
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/toll_lane_scheduler.sv
// rtl/toll_lane_scheduler.sv - assigns arriving vehicles to the least-occupied lane of their class
module toll_lane_scheduler
  import toll_pkg::*;
#(
  parameter int SVC_PRI  = 1,
  parameter int SVC_CASH = 4,
  parameter int SVC_ELEC = 2,
  parameter int TW       = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        arr_valid,
  output logic        arr_ready,
  input  logic        arr_priority,
  input  logic        arr_cash,
  output logic        assign_valid,
  output logic [2:0]  assign_lane,
  output logic [17:0] lane_count,
  output logic [5:0]  dep_valid,
  output logic        busy
);

  logic [CW-1:0]        cnt [NUM_LANES];
  logic [2:0]           grp_lo, grp_hi;
  logic [2:0]           idx_lo, idx_hi;
  logic [CW-1:0]        cnt_lo, cnt_hi;
  logic                 pick_hi;
  logic [2:0]           sel_lane, sel_idx;
  logic                 accept;
  logic [NUM_LANES-1:0] inc;

  // Class decode: priority wins over cash; everything else is electronic.
  always_comb begin
    grp_lo = ELEC_LO;
    grp_hi = ELEC_HI;
    if (arr_priority) begin
      grp_lo = PRI_LO;
      grp_hi = PRI_HI;
    end else if (arr_cash) begin
      grp_lo = CASH_LO;
      grp_hi = CASH_HI;
    end
  end

  assign idx_lo = grp_lo - 3'd1;
  assign idx_hi = grp_hi - 3'd1;
  assign cnt_lo = cnt[idx_lo];
  assign cnt_hi = cnt[idx_hi];

  // Strictly-less picks the upper lane, so ties go low; since CNT_MAX is the
  // largest count, a full lane is never chosen while its partner has room.
  assign pick_hi   = cnt_hi < cnt_lo;
  assign sel_lane  = pick_hi ? grp_hi : grp_lo;
  assign sel_idx   = sel_lane - 3'd1;
  assign arr_ready = enable && ((cnt_lo != CNT_MAX) || (cnt_hi != CNT_MAX));
  assign accept    = arr_valid && arr_ready;

  // One-hot increment toward the selected booth.
  always_comb begin
    inc = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      inc[i] = accept && (sel_idx == 3'(i));
    end
  end

  // Assignment report: one-cycle valid pulse, lane number held between accepts.
  always_ff @(posedge clk) begin
    if (reset) begin
      assign_valid <= 1'b0;
      assign_lane  <= 3'd0;
    end else begin
      assign_valid <= accept;
      if (accept) begin
        assign_lane <= sel_lane;
      end
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    localparam int SVC = (g < 2) ? SVC_PRI : ((g < 4) ? SVC_CASH : SVC_ELEC);

    toll_lane_booth #(
      .SVC (SVC),
      .TW  (TW)
    ) u_booth (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .inc       (inc[g]),
      .count     (cnt[g]),
      .dep_valid (dep_valid[g])
    );

    assign lane_count[CW*g +: CW] = cnt[g];
  end

  assign busy = |lane_count;

endmodule

// File: tb/tb_toll_lane_scheduler.sv
// tb/tb_toll_lane_scheduler.sv - scoreboard bench for the toll lane scheduler
module tb_toll_lane_scheduler;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        arr_valid;
  logic        arr_ready;
  logic        arr_priority;
  logic        arr_cash;
  logic        assign_valid;
  logic [2:0]  assign_lane;
  logic [17:0] lane_count;
  logic [5:0]  dep_valid;
  logic        busy;

  toll_lane_scheduler #(
    .SVC_PRI  (8),
    .SVC_CASH (4),
    .SVC_ELEC (2),
    .TW       (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .arr_valid    (arr_valid),
    .arr_ready    (arr_ready),
    .arr_priority (arr_priority),
    .arr_cash     (arr_cash),
    .assign_valid (assign_valid),
    .assign_lane  (assign_lane),
    .lane_count   (lane_count),
    .dep_valid    (dep_valid),
    .busy         (busy)
  );

  typedef struct {
    int         cyc;
    logic [5:0] val;
  } ev_t;

  typedef struct {
    int          cyc;
    int          kind;
    logic [17:0] val;
  } ck_t;

  ev_t aq[$];
  ev_t dq[$];
  ck_t cq[$];

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  logic done = 1'b0;

  ev_t         m_ev;
  ck_t         m_ck;
  logic [17:0] m_got;
  string       m_nm;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [17:0] lc(input int l1, input int l2, input int l3,
                                     input int l4, input int l5, input int l6);
    return {3'(l6), 3'(l5), 3'(l4), 3'(l3), 3'(l2), 3'(l1)};
  endfunction

  // Monitor: compares DUT outputs against the queued expectations mid-cycle.
  always @(negedge clk) begin
    if (assign_valid) begin
      vectors++;
      if (aq.size() == 0) begin
        miscompares++;
        $display("FAIL assign: got lane %0d at cycle %0d, required no assignment", assign_lane, cyc);
      end else begin
        m_ev = aq.pop_front();
        if (m_ev.cyc != cyc || m_ev.val[2:0] != assign_lane) begin
          miscompares++;
          $display("FAIL assign: got lane %0d at cycle %0d, required lane %0d at cycle %0d",
                   assign_lane, cyc, m_ev.val, m_ev.cyc);
        end
      end
    end else if (aq.size() != 0 && aq[0].cyc <= cyc) begin
      vectors++;
      miscompares++;
      m_ev = aq.pop_front();
      $display("FAIL assign: got none at cycle %0d, required lane %0d", cyc, m_ev.val);
    end

    if (dep_valid != 6'd0) begin
      vectors++;
      if (dq.size() == 0) begin
        miscompares++;
        $display("FAIL dep_valid: got %b at cycle %0d, required no departure", dep_valid, cyc);
      end else begin
        m_ev = dq.pop_front();
        if (m_ev.cyc != cyc || m_ev.val != dep_valid) begin
          miscompares++;
          $display("FAIL dep_valid: got %b at cycle %0d, required %b at cycle %0d",
                   dep_valid, cyc, m_ev.val, m_ev.cyc);
        end
      end
    end else if (dq.size() != 0 && dq[0].cyc <= cyc) begin
      vectors++;
      miscompares++;
      m_ev = dq.pop_front();
      $display("FAIL dep_valid: got none at cycle %0d, required %b", cyc, m_ev.val);
    end

    while (cq.size() != 0 && cq[0].cyc <= cyc) begin
      m_ck = cq.pop_front();
      vectors++;
      case (m_ck.kind)
        0:       begin m_got = lane_count;          m_nm = "lane_count";  end
        1:       begin m_got = {17'd0, arr_ready};  m_nm = "arr_ready";   end
        2:       begin m_got = {17'd0, busy};       m_nm = "busy";        end
        default: begin m_got = {15'd0, assign_lane}; m_nm = "assign_lane"; end
      endcase
      if (m_got != m_ck.val) begin
        miscompares++;
        $display("FAIL %s: got 0x%0h at cycle %0d, required 0x%0h", m_nm, m_got, cyc, m_ck.val);
      end
    end

    if (done) begin
      vectors++;
      if (aq.size() != 0 || dq.size() != 0 || cq.size() != 0) begin
        miscompares++;
        $display("FAIL drain: got %0d/%0d/%0d pending expectations, required 0/0/0",
                 aq.size(), dq.size(), cq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input int kind, input logic [17:0] val);
    ck_t t;
    t.cyc  = cyc;
    t.kind = kind;
    t.val  = val;
    cq.push_back(t);
  endtask

  task automatic push_dep(input int at, input logic [5:0] mask);
    ev_t t;
    t.cyc = at;
    t.val = mask;
    dq.push_back(t);
  endtask

  task automatic arrive(input logic p, input logic c, input int lane, output int e);
    ev_t t;
    arr_valid    = 1'b1;
    arr_priority = p;
    arr_cash     = c;
    e            = cyc + 1;
    t.cyc        = e;
    t.val        = 6'(lane);
    aq.push_back(t);
    tick(1);
    arr_valid = 1'b0;
  endtask

  initial begin
    int e0, e1, g;
    reset        = 1'b1;
    enable       = 1'b1;
    arr_valid    = 1'b0;
    arr_priority = 1'b0;
    arr_cash     = 1'b0;

    // Reset state
    tick(2);
    reset = 1'b0;
    chk(0, lc(0, 0, 0, 0, 0, 0));
    chk(1, 18'd1);
    chk(2, 18'd0);
    chk(3, 18'd0);

    // Cash balancing: 3, 4, 3
    arrive(1'b0, 1'b1, 3, e0);
    arrive(1'b0, 1'b1, 4, e1);
    arrive(1'b0, 1'b1, 3, g);
    push_dep(e0 + 5, 6'b000100);
    push_dep(e1 + 5, 6'b001000);
    push_dep(e0 + 9, 6'b000100);
    chk(0, lc(0, 0, 2, 1, 0, 0));
    tick(8);
    chk(0, lc(0, 0, 0, 0, 0, 0));
    chk(2, 18'd0);

    // Electronic service into empty lanes
    arr_cash = 1'b0;
    arrive(1'b0, 1'b0, 5, e0);
    push_dep(e0 + 3, 6'b010000);
    chk(0, lc(0, 0, 0, 0, 1, 0));
    chk(2, 18'd1);
    tick(2);
    chk(0, lc(0, 0, 0, 0, 1, 0));
    tick(1);
    chk(0, lc(0, 0, 0, 0, 0, 0));
    chk(2, 18'd0);

    // Simultaneous arrival and departure on lane 3
    arrive(1'b0, 1'b1, 3, e0);
    arrive(1'b0, 1'b1, 4, e1);
    push_dep(e0 + 5, 6'b000100);
    push_dep(e1 + 5, 6'b001000);
    push_dep(e0 + 9, 6'b000100);
    tick(3);
    arr_cash = 1'b1;
    chk(1, 18'd1);
    arrive(1'b0, 1'b1, 3, g);
    chk(0, lc(0, 0, 1, 1, 0, 0));
    tick(1);
    chk(0, lc(0, 0, 1, 0, 0, 0));
    tick(3);
    chk(0, lc(0, 0, 0, 0, 0, 0));

    // Freeze mid-service for 5 edges
    arrive(1'b0, 1'b0, 5, e0);
    tick(1);
    enable       = 1'b0;
    arr_valid    = 1'b1;
    arr_priority = 1'b0;
    arr_cash     = 1'b0;
    chk(1, 18'd0);
    tick(5);
    chk(0, lc(0, 0, 0, 0, 1, 0));
    arr_valid = 1'b0;
    enable    = 1'b1;
    push_dep(e0 + 8, 6'b010000);
    tick(1);
    chk(0, lc(0, 0, 0, 0, 1, 0));
    tick(1);
    chk(0, lc(0, 0, 0, 0, 0, 0));

    // Reset aborts service with no departure
    arrive(1'b0, 1'b0, 5, e0);
    arrive(1'b0, 1'b0, 6, e1);
    arrive(1'b0, 1'b0, 5, g);
    chk(0, lc(0, 0, 0, 0, 2, 1));
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk(0, lc(0, 0, 0, 0, 0, 0));
    chk(2, 18'd0);
    chk(3, 18'd0);
    tick(4);
    chk(0, lc(0, 0, 0, 0, 0, 0));

    // Fill the priority group to 7/7 with 8-cycle service
    g = cyc + 1;
    push_dep(g + 9, 6'b000001);
    push_dep(g + 10, 6'b000010);
    for (int i = 0; i < 16; i++) begin
      arrive(1'b1, 1'b0, (i % 2 == 0) ? 1 : 2, e0);
    end
    arr_priority = 1'b1;
    chk(1, 18'd0);
    chk(0, lc(7, 7, 0, 0, 0, 0));
    tick(1);
    arr_priority = 1'b0;
    arr_cash     = 1'b1;
    chk(1, 18'd1);
    chk(0, lc(7, 7, 0, 0, 0, 0));
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk(0, lc(0, 0, 0, 0, 0, 0));
    chk(2, 18'd0);

    tick(3);
    done = 1'b1;
  end

endmodule
